// File: rtl/hnf_mshr_wakeup_sched.sv
// hnf_mshr_wakeup_sched: parks MSHR entries that hit an address hazard and
// re-issues them one per handshake, round-robin, once their blocker retires.
// Ports: clk, rst (async, active-high)
//   sleep_valid_sx3/sleep_entry_sx3/hazard_entry_sx3 : hazard sleep request
//   retire_valid_sx1/retire_idx_sx1                  : MSHR retire
//   wake_valid/wake_idx/wake_ready                   : wake handshake
//   sleep_vec, busy, sched_err                       : status
// Optional: define HNF_WAKEUP_CHECK_EN to build the sticky protocol checker.
module hnf_mshr_wakeup_sched #(
    parameter int MSHR_ENTRIES_NUM   = 32,
    parameter int MSHR_ENTRIES_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sleep_valid_sx3,
    input  logic [MSHR_ENTRIES_NUM-1:0]   sleep_entry_sx3,
    input  logic [MSHR_ENTRIES_NUM-1:0]   hazard_entry_sx3,
    input  logic                          retire_valid_sx1,
    input  logic [MSHR_ENTRIES_WIDTH-1:0] retire_idx_sx1,
    output logic                          wake_valid,
    output logic [MSHR_ENTRIES_WIDTH-1:0] wake_idx,
    input  logic                          wake_ready,
    output logic [MSHR_ENTRIES_NUM-1:0]   sleep_vec,
    output logic                          busy,
    output logic                          sched_err
);
    localparam int N = MSHR_ENTRIES_NUM;
    localparam int W = MSHR_ENTRIES_WIDTH;

    logic [N-1:0] r_asleep;
    logic [N-1:0] r_pend;
    logic [W-1:0] r_dep [N];
    logic         r_wake_valid;
    logic [W-1:0] r_wake_idx;
    logic [W-1:0] r_rr_ptr;

    logic [N-1:0] w_asleep_nxt;
    logic [N-1:0] w_pend_nxt;
    logic [W-1:0] w_dep_nxt [N];
    logic         w_wv_nxt;
    logic [W-1:0] w_wi_nxt;
    logic [W-1:0] w_rr_nxt;
    logic [N-1:0] w_cand;
    logic         w_found;
    logic [W-1:0] w_win;

    // Lowest set bit wins if the vector is not one-hot.
    function automatic logic [W-1:0] f_idx(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--)
            if (v[i]) r = W'(i);
        return r;
    endfunction

    logic         w_sleep_ev;
    logic [W-1:0] w_s;
    logic [W-1:0] w_h;
    logic         w_hs;
    logic         w_ret_asleep;
    logic         w_kill;

    assign w_sleep_ev   = sleep_valid_sx3 && (|sleep_entry_sx3) && (|hazard_entry_sx3);
    assign w_s          = f_idx(sleep_entry_sx3);
    assign w_h          = f_idx(hazard_entry_sx3);
    assign w_hs         = r_wake_valid && wake_ready;
    assign w_ret_asleep = retire_valid_sx1 && r_asleep[retire_idx_sx1];
    // Retiring the presented entry withdraws the request.
    assign w_kill       = w_ret_asleep && r_wake_valid && (retire_idx_sx1 == r_wake_idx);

    always_comb begin
        w_asleep_nxt = r_asleep;
        w_pend_nxt   = r_pend;
        w_dep_nxt    = r_dep;
        for (int i = 0; i < N; i++)
            if (retire_valid_sx1 && r_asleep[i] && !r_pend[i] && (r_dep[i] == retire_idx_sx1))
                w_pend_nxt[i] = 1'b1;
        if (w_ret_asleep) begin
            w_asleep_nxt[retire_idx_sx1] = 1'b0;
            w_pend_nxt[retire_idx_sx1]   = 1'b0;
        end
        if (w_hs && r_pend[r_wake_idx]) begin
            w_asleep_nxt[r_wake_idx] = 1'b0;
            w_pend_nxt[r_wake_idx]   = 1'b0;
        end
        // A new sleep overrides everything else on that entry; a blocker
        // retiring in the same cycle sends it straight to PEND.
        if (w_sleep_ev) begin
            w_asleep_nxt[w_s] = 1'b1;
            w_pend_nxt[w_s]   = retire_valid_sx1 && (w_h == retire_idx_sx1);
            w_dep_nxt[w_s]    = w_h;
        end
    end

    // Drop entries leaving PEND this edge so the output never shows a stale one.
    always_comb begin
        w_cand = r_pend;
        if (w_hs)             w_cand = w_cand & ~(N'(1) << r_wake_idx);
        if (retire_valid_sx1) w_cand = w_cand & ~(N'(1) << retire_idx_sx1);
        if (w_sleep_ev)       w_cand = w_cand & ~(N'(1) << w_s);
    end

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_cand[(int'(r_rr_ptr) + k) % N]) begin
                w_found = 1'b1;
                w_win   = W'((int'(r_rr_ptr) + k) % N);
            end
        end
    end

    always_comb begin
        w_wv_nxt = r_wake_valid;
        w_wi_nxt = r_wake_idx;
        w_rr_nxt = r_rr_ptr;
        if (w_kill) begin
            w_wv_nxt = 1'b0;
        end else if (!r_wake_valid || w_hs) begin
            w_wv_nxt = w_found;
            if (w_found) w_wi_nxt = w_win;
        end
        if (w_hs)
            w_rr_nxt = (int'(r_wake_idx) == N - 1) ? '0 : r_wake_idx + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_asleep     <= '0;
            r_pend       <= '0;
            for (int i = 0; i < N; i++) r_dep[i] <= '0;
            r_wake_valid <= 1'b0;
            r_wake_idx   <= '0;
            r_rr_ptr     <= '0;
        end else begin
            r_asleep     <= w_asleep_nxt;
            r_pend       <= w_pend_nxt;
            r_dep        <= w_dep_nxt;
            r_wake_valid <= w_wv_nxt;
            r_wake_idx   <= w_wi_nxt;
            r_rr_ptr     <= w_rr_nxt;
        end
    end

    assign wake_valid = r_wake_valid;
    assign wake_idx   = r_wake_idx;
    assign sleep_vec  = r_asleep;
    assign busy       = |r_asleep;

`ifdef HNF_WAKEUP_CHECK_EN
`ifndef DISPLAY_FATAL
`define DISPLAY_FATAL(MSG) $display("FATAL %s", MSG)
`endif
    function automatic logic f_onehot(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    logic w_e_onehot;
    logic w_e_self;
    logic w_e_resleep;
    logic w_e_retire;
    logic w_e_hold;
    logic r_sched_err;

    assign w_e_onehot  = sleep_valid_sx3 &&
                         (!f_onehot(sleep_entry_sx3) || !f_onehot(hazard_entry_sx3));
    assign w_e_self    = sleep_valid_sx3 && (sleep_entry_sx3 == hazard_entry_sx3);
    assign w_e_resleep = w_sleep_ev && r_asleep[w_s];
    assign w_e_retire  = w_ret_asleep;
    assign w_e_hold    = r_wake_valid && !wake_ready && w_wv_nxt && (w_wi_nxt != r_wake_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sched_err <= 1'b0;
        end else begin
            if (w_e_onehot)  `DISPLAY_FATAL("wakeup_sched: sleep/hazard not one-hot");
            if (w_e_self)    `DISPLAY_FATAL("wakeup_sched: entry sleeps on itself");
            if (w_e_resleep) `DISPLAY_FATAL("wakeup_sched: sleep on asleep entry");
            if (w_e_retire)  `DISPLAY_FATAL("wakeup_sched: retire of asleep entry");
            if (w_e_hold)    `DISPLAY_FATAL("wakeup_sched: wake_idx changed under hold");
            if (w_e_onehot || w_e_self || w_e_resleep || w_e_retire || w_e_hold)
                r_sched_err <= 1'b1;
        end
    end

    assign sched_err = r_sched_err;
`else
    assign sched_err = 1'b0;
`endif

endmodule

// File: tb/tb_hnf_mshr_wakeup_sched.sv
// Testbench for hnf_mshr_wakeup_sched: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_hnf_mshr_wakeup_sched;
    localparam int N = 32;
    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         sleep_valid_sx3;
    logic [N-1:0] sleep_entry_sx3;
    logic [N-1:0] hazard_entry_sx3;
    logic         retire_valid_sx1;
    logic [W-1:0] retire_idx_sx1;
    logic         wake_valid;
    logic [W-1:0] wake_idx;
    logic         wake_ready;
    logic [N-1:0] sleep_vec;
    logic         busy;
    logic         sched_err;

    hnf_mshr_wakeup_sched #(.MSHR_ENTRIES_NUM(N), .MSHR_ENTRIES_WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .sleep_valid_sx3(sleep_valid_sx3), .sleep_entry_sx3(sleep_entry_sx3),
        .hazard_entry_sx3(hazard_entry_sx3),
        .retire_valid_sx1(retire_valid_sx1), .retire_idx_sx1(retire_idx_sx1),
        .wake_valid(wake_valid), .wake_idx(wake_idx), .wake_ready(wake_ready),
        .sleep_vec(sleep_vec), .busy(busy), .sched_err(sched_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input bit sv, input int s, input int h,
                         input bit rv, input int ri, input bit wr);
        sleep_valid_sx3  = sv;
        sleep_entry_sx3  = sv ? (32'(1) << s) : '0;
        hazard_entry_sx3 = sv ? (32'(1) << h) : '0;
        retire_valid_sx1 = rv;
        retire_idx_sx1   = W'(ri);
        wake_ready       = wr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        bit sv; int s; int h; bit rv; int ri; bit wr;
        bit ewv; int ewi; logic [31:0] evec;
    } vec_t;
    vec_t tbl[14];

    // Behavioural model state
    bit m_as[N];
    bit m_pd[N];
    int m_dp[N];
    bit m_wv;
    int m_wi;
    int m_rr;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_as[i] = 0; m_pd[i] = 0; m_dp[i] = 0;
        end
        m_wv = 0; m_wi = 0; m_rr = 0;
    endtask

    task automatic model_step(input bit sv, input int s, input int h,
                              input bit rv, input int ri, input bit wr);
        bit na[N]; bit np[N]; int nd[N];
        bit hs; bit kill; int best; int bd;
        hs = m_wv && wr;
        kill = rv && m_wv && (ri == m_wi) && m_as[ri];
        na = m_as; np = m_pd; nd = m_dp;
        for (int i = 0; i < N; i++)
            if (rv && m_as[i] && !m_pd[i] && m_dp[i] == ri) np[i] = 1;
        if (rv && m_as[ri]) begin na[ri] = 0; np[ri] = 0; end
        if (hs && m_pd[m_wi]) begin na[m_wi] = 0; np[m_wi] = 0; end
        if (sv) begin na[s] = 1; np[s] = rv && (h == ri); nd[s] = h; end
        if (kill) begin
            m_wv = 0;
        end else if (!m_wv || hs) begin
            best = -1; bd = N;
            for (int j = 0; j < N; j++) begin
                if (m_pd[j] && !(hs && j == m_wi) && !(rv && j == ri) && !(sv && j == s)
                    && ((j - m_rr + N) % N) < bd) begin
                    bd = (j - m_rr + N) % N;
                    best = j;
                end
            end
            m_wv = (best >= 0);
            if (best >= 0) m_wi = best;
        end
        if (hs) m_rr = (m_wi_prev_next(hs)) ;
        m_as = na; m_pd = np; m_dp = nd;
    endtask

    // rr pointer follows the entry that was handshaken (captured before reload)
    int m_hs_idx;
    function automatic int m_wi_prev_next(input bit hs);
        return hs ? (m_hs_idx + 1) % N : m_rr;
    endfunction

    logic [31:0] mvec;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        bit sv; bit rv; bit wr; int s; int h; int ri; bit got;
        rst = 1'b0;
        do_reset();
        chk("reset_wake_valid", 32'(wake_valid), 0);
        chk("reset_wake_idx", 32'(wake_idx), 0);
        chk("reset_sleep_vec", sleep_vec, 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_sched_err", 32'(sched_err), 0);

        // Basic wake
        apply(1, 5, 2, 0, 0, 0);
        chk("basic_sleep_vec", sleep_vec, 32'h20);
        apply(0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 1, 2, 0);
        chk("basic_no_early_wake", 32'(wake_valid), 0);
        apply(0, 0, 0, 0, 0, 0);
        chk("basic_wake", {wake_valid, 26'd0, wake_idx}, {1'b1, 26'd0, 5'd5});
        apply(0, 0, 0, 0, 0, 1);
        chk("basic_done_valid", 32'(wake_valid), 0);
        chk("basic_done_vec", sleep_vec, 0);
        chk("basic_done_busy", 32'(busy), 0);

        // Fan-out and round-robin wrap
        tbl[0]  = '{1, 3, 7, 0, 0, 0, 0, 0, 32'h0000_0008};
        tbl[1]  = '{1, 9, 7, 0, 0, 0, 0, 0, 32'h0000_0208};
        tbl[2]  = '{1, 30, 7, 0, 0, 0, 0, 0, 32'h4000_0208};
        tbl[3]  = '{0, 0, 0, 1, 7, 1, 0, 0, 32'h4000_0208};
        tbl[4]  = '{0, 0, 0, 0, 0, 1, 1, 3, 32'h4000_0208};
        tbl[5]  = '{0, 0, 0, 0, 0, 1, 1, 9, 32'h4000_0200};
        tbl[6]  = '{0, 0, 0, 0, 0, 1, 1, 30, 32'h4000_0000};
        tbl[7]  = '{0, 0, 0, 0, 0, 1, 0, 0, 32'h0000_0000};
        tbl[8]  = '{1, 0, 1, 0, 0, 0, 0, 0, 32'h0000_0001};
        tbl[9]  = '{1, 31, 1, 0, 0, 0, 0, 0, 32'h8000_0001};
        tbl[10] = '{0, 0, 0, 1, 1, 0, 0, 0, 32'h8000_0001};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 1, 31, 32'h8000_0001};
        tbl[12] = '{0, 0, 0, 0, 0, 1, 1, 0, 32'h0000_0001};
        tbl[13] = '{0, 0, 0, 0, 0, 1, 0, 0, 32'h0000_0000};
        do_reset();
        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].sv, tbl[i].s, tbl[i].h, tbl[i].rv, tbl[i].ri, tbl[i].wr);
            chk($sformatf("tbl%0d_valid", i), 32'(wake_valid), 32'(tbl[i].ewv));
            if (tbl[i].ewv) chk($sformatf("tbl%0d_idx", i), 32'(wake_idx), 32'(tbl[i].ewi));
            chk($sformatf("tbl%0d_vec", i), sleep_vec, tbl[i].evec);
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].evec != 0));
        end

        // Backpressure: output held while a new candidate appears
        do_reset();
        apply(1, 4, 2, 0, 0, 0);
        apply(1, 1, 3, 0, 0, 0);
        apply(0, 0, 0, 1, 2, 0);
        apply(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            apply(0, 0, 0, (c == 3), 3, 0);
            chk($sformatf("bp_hold%0d", c), {wake_valid, 26'd0, wake_idx}, {1'b1, 26'd0, 5'd4});
        end
        apply(0, 0, 0, 0, 0, 1);
        chk("bp_next", {wake_valid, 26'd0, wake_idx}, {1'b1, 26'd0, 5'd1});
        apply(0, 0, 0, 0, 0, 1);
        chk("bp_drain_valid", 32'(wake_valid), 0);
        chk("bp_drain_busy", 32'(busy), 0);

        // Same-cycle sleep and retire of its blocker
        do_reset();
        apply(1, 6, 2, 1, 2, 0);
        chk("same_cycle_vec", sleep_vec, 32'h40);
        got = 0;
        for (int c = 0; c < 8 && !got; c++) begin
            apply(0, 0, 0, 0, 0, 0);
            got = wake_valid;
        end
        chk("same_cycle_wake", {got, 26'd0, wake_idx}, {1'b1, 26'd0, 5'd6});
        apply(0, 0, 0, 0, 0, 1);
        chk("same_cycle_busy", 32'(busy), 0);

        // Reset in the middle of an outstanding wake
        apply(1, 5, 2, 0, 0, 0);
        apply(0, 0, 0, 1, 2, 0);
        apply(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_outputs", {wake_valid, busy, sched_err, 24'd0, wake_idx},
            {3'b000, 24'd0, 5'd0});
        chk("midrst_vec", sleep_vec, 0);
        rst = 1'b0;

        // Malformed sleep vector
        sleep_valid_sx3  = 1'b1;
        sleep_entry_sx3  = 32'h6;
        hazard_entry_sx3 = 32'h1;
        retire_valid_sx1 = 1'b0;
        wake_ready       = 1'b0;
        @(posedge clk);
        #1;
        apply(0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
`ifdef HNF_WAKEUP_CHECK_EN
        chk("err_sticky", 32'(sched_err), 1);
        do_reset();
        chk("err_cleared", 32'(sched_err), 0);
`else
        chk("err_tied_low", 32'(sched_err), 0);
        do_reset();
`endif

        // Randomized run against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            sv = 0; s = 0; h = 0; rv = 0; ri = 0;
            if ($urandom_range(0, 2) == 0) begin
                s = $urandom_range(0, N - 1);
                h = $urandom_range(0, 7);
                if (!m_as[s] && h != s) sv = 1;
            end
            if ($urandom_range(0, 3) == 0) begin
                ri = $urandom_range(0, 7);
                if (!m_as[ri]) rv = 1;
            end
            wr = 1'($urandom_range(0, 1));
            m_hs_idx = m_wi;
            model_step(sv, s, h, rv, ri, wr);
            apply(sv, s, h, rv, ri, wr);
            mvec = '0;
            for (int i = 0; i < N; i++) mvec[i] = m_as[i];
            chk($sformatf("rnd%0d_valid", c), 32'(wake_valid), 32'(m_wv));
            if (m_wv) chk($sformatf("rnd%0d_idx", c), 32'(wake_idx), 32'(m_wi));
            chk($sformatf("rnd%0d_vec", c), sleep_vec, mvec);
            chk($sformatf("rnd%0d_busy", c), 32'(busy), 32'(mvec != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hnf_mshr_wakeup_sched.md
Name: hnf_mshr_wakeup_sched

Overview:
Tracks MSHR entries put to sleep by the pipeline address-hazard check, together with the entry each one waits on. When a blocking entry retires, the block marks its dependents ready to wake. It then re-issues them to the MSHR control one per handshake, in round-robin order. It sits between the MSHR address buffer hazard outputs, the MSHR retire path and the MSHR-to-cache-pipeline issue logic.

Parameters:
MSHR_ENTRIES_NUM, 32, number of MSHR entries
MSHR_ENTRIES_WIDTH, 5, log2(MSHR_ENTRIES_NUM), entry index width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
sleep_valid_sx3  in  1  pipeline hazard detected this cycle
sleep_entry_sx3  in  N  one-hot entry to put to sleep
hazard_entry_sx3  in  N  one-hot entry it depends on
retire_valid_sx1  in  1  MSHR entry retiring
retire_idx_sx1  in  W  retiring entry index
wake_valid  out  1  wake request to MSHR control
wake_idx  out  W  entry to wake
wake_ready  in  1  MSHR control accepts wake
sleep_vec  out  N  entries currently asleep (sleep or pending)
busy  out  1  OR of sleep_vec
sched_err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Width convention: N = MSHR_ENTRIES_NUM, W = MSHR_ENTRIES_WIDTH.
- Per-entry state: asleep[i], pending[i], dep_q[i] (W bits). State is encoded as IDLE (asleep=0), SLEEP (asleep=1, pending=0), PEND (asleep=1, pending=1).
- Reset: all asleep, pending and dep_q cleared; wake_valid=0, wake_idx=0, rr_ptr=0, sched_err=0.
- Sleep event:
  - Condition: sleep_valid_sx3=1 and both vectors are non-zero.
  - At the next edge, entry s = index(sleep_entry_sx3) goes IDLE->SLEEP and dep_q[s] = index(hazard_entry_sx3).
  - If either vector is zero, the event is ignored.
- Retire:
  - Every entry in SLEEP with dep_q == retire_idx_sx1 goes to PEND at the next edge.
  - Same-cycle sleep event whose hazard entry equals retire_idx_sx1: entry s enters PEND directly, so no lost wakeup.
  - Retire of an entry that is itself asleep forces it to IDLE at the next edge. If it is the entry being presented, wake_valid drops at the same edge.
- Arbitration:
  - Round-robin over pending, starting from rr_ptr and searching upward with wrap from N-1 to 0.
  - Result feeds a registered output stage.
- Output load, with wake_valid=0 or a handshake this cycle (wake_valid & wake_ready):
  - If any candidate is pending, load wake_valid=1 and wake_idx=winner.
  - The entry just handshaken is excluded from candidates, which allows back-to-back wakes.
- Hold: while wake_valid=1 and wake_ready=0, wake_valid and wake_idx are held stable (no re-arbitration).
- Handshake: at the edge, entry wake_idx goes PEND->IDLE and rr_ptr = wake_idx+1 (mod N).
- Latency: retire at edge T -> pending at T+1 -> wake_valid at T+2 (with output stage empty).
- Simultaneous sleep event and handshake on the same entry: the sleep event wins, and the entry re-enters SLEEP with the new dep_q.
- Sleep event on an entry already asleep: overwrite dep_q and return the entry to SLEEP (pending cleared); sched_err is flagged under the feature.
- Outputs: sleep_vec = asleep; busy = |asleep.

Optional Feature:
Macro HNF_WAKEUP_CHECK_EN.
- With the macro, sched_err is set sticky (cleared only by rst) on any of:
  - sleep_entry_sx3 or hazard_entry_sx3 not one-hot during sleep_valid_sx3;
  - sleep entry == hazard entry;
  - sleep event on an already-asleep entry;
  - retire of an asleep entry;
  - wake_idx changing while wake_valid=1 and wake_ready=0.
- With the macro, a `display_fatal is also issued for each of these conditions.
- Without the macro, sched_err is tied 0 and no check logic is built. Functional behaviour is identical in both builds.

Test Plan:
- Basic wake: sleep entry 5 on hazard 2; retire idx 2 two cycles later -> wake_valid=1, wake_idx=5 two cycles after retire; on ready, sleep_vec[5]=0 and busy=0.
- Fan-out: entries 3, 9 and 30 sleep on hazard 7; retire 7 with ready held 1 -> wakes 3, 9, 30 on consecutive cycles; rr_ptr=31 afterwards.
- Round-robin wrap: rr_ptr=31, pending {0, 31} -> order 31, then 0.
- Backpressure: pending 4, wake_ready=0 for 10 cycles -> wake_valid=1 and wake_idx=4 stable throughout; a later retire adding pending 1 does not change wake_idx until handshake.
- Same-cycle sleep and retire: sleep entry 6 on hazard 2 in the same cycle as retire idx 2 -> entry 6 woken; no hang.
- Errors (HNF_WAKEUP_CHECK_EN): sleep_entry_sx3=0b0110 -> sched_err=1 and stays 1 until rst; mid-operation rst -> all outputs 0 next cycle.
